// File: rtl/timer_master_pkg.sv
// Shared constants and state encoding for the interval-timer Avalon-MM master.
package timer_master_pkg;

  // Interval-timer slave word addresses
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control register bit positions
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Control words: run continuously with interrupt enabled, or halt
  localparam logic [15:0] CTRL_RUN  = 16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
  localparam logic [15:0] CTRL_HALT = 16'(1 << CTRL_STOP);

  typedef enum logic [3:0] {
    StIdle,
    StCfgPl,
    StCfgPh,
    StCfgCtrl,
    StRun,
    StAck,
    StStopW,
    StSnapW,
    StSnapRl,
    StSnapRh,
    StSnapCap
  } state_e;

endpackage

// File: rtl/timer_tick_master.sv
// Avalon-MM master that programs the interval timer, services its timeout
// interrupt as tick pulses and reads counter snapshots on request.
module timer_tick_master
  import timer_master_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0001D4BF,
  parameter int unsigned TICK_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period_in,
  input  logic              snap_req,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snap_valid,
  output logic              busy,
  output logic              running,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              irq
);

  state_e              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                stop_pend_q, stop_pend_d;
  logic                snap_pend_q, snap_pend_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [31:0]         snapshot_q, snapshot_d;
  logic                running_q, running_d;
  logic                tick_q, tick_d;
  logic                snap_valid_q, snap_valid_d;
  logic                busy_q, busy_d;
  logic [2:0]          address_q, address_d;
  logic                cs_q, cs_d;
  logic                write_n_q, write_n_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                stop_any, snap_any;

  assign stop_any = stop | stop_pend_q;
  assign snap_any = snap_req | snap_pend_q;

  // Next-state, request bookkeeping and datapath updates
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    stop_pend_d  = stop_pend_q;
    snap_pend_d  = snap_pend_q;
    tick_count_d = tick_count_q;
    snapshot_d   = snapshot_q;
    running_d    = running_q;
    snap_valid_d = 1'b0;

    // Requests landing outside IDLE are remembered until RUN can act on them
    if (state_q != StIdle) begin
      if (stop)     stop_pend_d = 1'b1;
      if (snap_req) snap_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          period_d     = (period_in == '0) ? DEFAULT_PERIOD : period_in;
          tick_count_d = '0;
          state_d      = StCfgPl;
        end
      end
      StCfgPl:   state_d = StCfgPh;
      StCfgPh:   state_d = StCfgCtrl;
      StCfgCtrl: begin
        state_d   = StRun;
        running_d = 1'b1;
      end
      StRun: begin
        if (irq) begin
          // Counter advances together with the tick pulse in ACK
          state_d      = StAck;
          tick_count_d = tick_count_q + 1'b1;
        end else if (stop_any) begin
          state_d     = StStopW;
          stop_pend_d = 1'b0;
        end else if (snap_any) begin
          state_d     = StSnapW;
          snap_pend_d = 1'b0;
        end
      end
      StAck:   state_d = StRun;
      StStopW: begin
        state_d     = StIdle;
        running_d   = 1'b0;
        stop_pend_d = 1'b0;
        snap_pend_d = 1'b0;
      end
      StSnapW:  state_d = StSnapRl;
      StSnapRl: state_d = StSnapRh;
      StSnapRh: begin
        snapshot_d[15:0] = readdata;
        state_d          = StSnapCap;
      end
      StSnapCap: begin
        snapshot_d[31:16] = readdata;
        snap_valid_d      = 1'b1;
        state_d           = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered bus and pulse outputs decoded from the state being entered
  always_comb begin
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    address_d = ADDR_STATUS;
    wdata_d   = 16'h0000;
    tick_d    = (state_d == StAck);
    busy_d    = !(state_d inside {StIdle, StRun});
    unique case (state_d)
      StCfgPl:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_PERIOD_L;
                       wdata_d = period_d[15:0]; end
      StCfgPh:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_PERIOD_H;
                       wdata_d = period_d[31:16]; end
      StCfgCtrl: begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_CONTROL;
                       wdata_d = CTRL_RUN; end
      StAck:     begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_STATUS; end
      StStopW:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_CONTROL;
                       wdata_d = CTRL_HALT; end
      StSnapW:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = ADDR_SNAP_L; end
      StSnapRl:  begin cs_d = 1'b1; address_d = ADDR_SNAP_L; end
      StSnapRh:  begin cs_d = 1'b1; address_d = ADDR_SNAP_H; end
      default:   ;
    endcase
  end

  // State and output registers; reset aborts any bus sequence at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      period_q     <= '0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      tick_count_q <= '0;
      snapshot_q   <= '0;
      running_q    <= 1'b0;
      tick_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      address_q    <= '0;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      tick_count_q <= tick_count_d;
      snapshot_q   <= snapshot_d;
      running_q    <= running_d;
      tick_q       <= tick_d;
      snap_valid_q <= snap_valid_d;
      busy_q       <= busy_d;
      address_q    <= address_d;
      cs_q         <= cs_d;
      write_n_q    <= write_n_d;
      wdata_q      <= wdata_d;
    end
  end

  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
  assign busy       = busy_q;
  assign running    = running_q;
  assign address    = address_q;
  assign chipselect = cs_q;
  assign write_n    = write_n_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master: drives a behavioural interval-timer slave and
// checks bus writes, ticks and snapshots through scoreboard queues.
module tb_timer_tick_master;

  localparam logic [31:0] DEF_P = 32'h0001D4BF;

  logic        clk = 1'b0;
  logic        reset, start, stop, snap_req;
  logic [31:0] period_in;
  logic        tick, snap_valid, busy, running, chipselect, write_n, irq;
  logic [15:0] tick_count, writedata, readdata;
  logic [31:0] snapshot;
  logic [2:0]  address;

  always #5 clk = ~clk;

  timer_tick_master #(.DEFAULT_PERIOD(DEF_P), .TICK_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period_in(period_in),
    .snap_req(snap_req), .tick(tick), .tick_count(tick_count), .snapshot(snapshot),
    .snap_valid(snap_valid), .busy(busy), .running(running), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // ---------------- interval-timer slave model ----------------
  logic [15:0] s_per_l, s_per_h, s_rdata;
  logic [31:0] s_cnt, s_snap;
  logic        s_to, s_run, s_ito, s_cont;
  logic [31:0] snap_exp_q[$];

  assign irq      = s_to & s_ito;
  assign readdata = s_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_per_l <= '0; s_per_h <= '0; s_rdata <= '0; s_cnt <= '0; s_snap <= '0;
      s_to <= 1'b0; s_run <= 1'b0; s_ito <= 1'b0; s_cont <= 1'b0;
      snap_exp_q.delete();
    end else begin
      if (s_run) begin
        if (s_cnt == 0) begin
          s_to  <= 1'b1;
          s_cnt <= {s_per_h, s_per_l};
          if (!s_cont) s_run <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: s_to <= 1'b0;
          3'd1: begin
            s_ito  <= writedata[0];
            s_cont <= writedata[1];
            if (writedata[2]) begin s_run <= 1'b1; s_cnt <= {s_per_h, s_per_l}; end
            if (writedata[3]) s_run <= 1'b0;
          end
          3'd2: s_per_l <= writedata;
          3'd3: s_per_h <= writedata;
          3'd4, 3'd5: begin s_snap <= s_cnt; snap_exp_q.push_back(s_cnt); end
          default: ;
        endcase
      end
      case (address)
        3'd0: s_rdata <= {14'd0, s_run, s_to};
        3'd1: s_rdata <= {14'd0, s_cont, s_ito};
        3'd2: s_rdata <= s_per_l;
        3'd3: s_rdata <= s_per_h;
        3'd4: s_rdata <= s_snap[15:0];
        3'd5: s_rdata <= s_snap[31:16];
        default: s_rdata <= '0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        chk;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] tick_exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          cyc = 0, ticks_seen = 0, snaps_seen = 0, last_tick_cyc = 0, irq_len = 0;
  int          cur_period = 0;
  bit          first_tick = 1'b1;

  function automatic wr_t mk_wr(input logic [2:0] a, input logic [15:0] d, input logic c);
    wr_t w;
    w.addr = a; w.data = d; w.chk = c;
    return w;
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin : mon
    wr_t         e;
    logic [15:0] t;
    logic [31:0] s;
    #1;
    cyc++;
    if (reset) begin
      irq_len = 0;
    end else begin
      if (chipselect && !write_n) begin
        if (wr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   address, writedata);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", {29'd0, address}, {29'd0, e.addr});
          if (e.chk) check("wr_data", {16'd0, writedata}, {16'd0, e.data});
        end
      end
      if (chipselect && write_n) check("read_addr_4_or_5", (address == 3'd4 || address == 3'd5), 1);
      if (tick) begin
        ticks_seen++;
        if (tick_exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_tick: got count %0d, expected no tick", tick_count);
        end else begin
          t = tick_exp_q.pop_front();
          check("tick_count", {16'd0, tick_count}, {16'd0, t});
        end
        if (!first_tick) check("tick_interval", cyc - last_tick_cyc, cur_period + 1);
        first_tick    = 1'b0;
        last_tick_cyc = cyc;
      end
      if (snap_valid) begin
        snaps_seen++;
        if (snap_exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_snap_valid: got 0x%0h, expected no pulse", snapshot);
        end else begin
          s = snap_exp_q.pop_front();
          check("snapshot", snapshot, s);
        end
      end
      if (irq) irq_len++;
      else begin
        if (irq_len > 0) check("irq_len_le3", (irq_len <= 3), 1);
        irq_len = 0;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_start(input logic [31:0] p);
    logic [31:0] eff;
    eff = (p == 0) ? DEF_P : p;
    // stop/snap in IDLE must have no effect
    @(negedge clk); stop = 1'b1; snap_req = 1'b1;
    @(negedge clk); stop = 1'b0; snap_req = 1'b0;
    wr_q.push_back(mk_wr(3'd2, eff[15:0], 1'b1));
    wr_q.push_back(mk_wr(3'd3, eff[31:16], 1'b1));
    wr_q.push_back(mk_wr(3'd1, 16'h0007, 1'b1));
    exp_cnt    = '0;
    cur_period = int'(eff);
    first_tick = 1'b1;
    start = 1'b1; period_in = p;
    @(negedge clk); start = 1'b0; period_in = $urandom;
    repeat (2) @(negedge clk);
    check("cfg_running_low", running, 0);
    check("cfg_busy_high", busy, 1);
    @(negedge clk);
    check("run_running_high", running, 1);
    check("run_busy_low", busy, 0);
  endtask

  task automatic expect_ticks(input int n);
    int target, budget, k;
    for (int i = 0; i < n; i++) begin
      exp_cnt = exp_cnt + 16'd1;
      tick_exp_q.push_back(exp_cnt);
      wr_q.push_back(mk_wr(3'd0, 16'h0000, 1'b1));
    end
    target = ticks_seen + n;
    budget = n * (cur_period + 1) + 40;
    k = 0;
    while (ticks_seen < target && k < budget) begin @(negedge clk); k++; end
    if (ticks_seen < target) fail_now("wait_ticks");
    check("tick_count_after_wait", {16'd0, tick_count}, {16'd0, exp_cnt});
  endtask

  task automatic do_snap(input bit extra);
    int target, k;
    target = snaps_seen + (extra ? 2 : 1);
    wr_q.push_back(mk_wr(3'd4, 16'h0000, 1'b0));
    if (extra) wr_q.push_back(mk_wr(3'd4, 16'h0000, 1'b0));
    @(negedge clk); snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    if (extra) begin
      // two pulses while busy coalesce into one further snapshot
      @(negedge clk); snap_req = 1'b1;
      @(negedge clk); snap_req = 1'b0;
      @(negedge clk); snap_req = 1'b1;
      @(negedge clk); snap_req = 1'b0;
    end
    k = 0;
    while (snaps_seen < target && k < 30) begin @(negedge clk); k++; end
    if (snaps_seen < target) fail_now("wait_snap");
    repeat (6) @(negedge clk);
    check("snap_count", snaps_seen, target);
  endtask

  task automatic do_stop(input bit on_irq);
    int k;
    if (on_irq) begin
      @(negedge clk);
      k = 0;
      while (!irq && k < cur_period + 10) begin @(negedge clk); k++; end
      if (!irq) fail_now("wait_irq");
      exp_cnt = exp_cnt + 16'd1;
      tick_exp_q.push_back(exp_cnt);
      wr_q.push_back(mk_wr(3'd0, 16'h0000, 1'b1));
    end
    wr_q.push_back(mk_wr(3'd1, 16'h0008, 1'b1));
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (5) @(negedge clk);
    check("stopped_running", running, 0);
    check("stopped_busy", busy, 0);
    check("stopped_tick_count", {16'd0, tick_count}, {16'd0, exp_cnt});
    check("wr_queue_drained", wr_q.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_chipselect", chipselect, 0);
    check("rst_write_n", write_n, 1);
    check("rst_address", {29'd0, address}, 0);
    check("rst_writedata", {16'd0, writedata}, 0);
    check("rst_tick", tick, 0);
    check("rst_snap_valid", snap_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_tick_count", {16'd0, tick_count}, 0);
    check("rst_snapshot", snapshot, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_reset_state();
    check("rst_no_pending_writes", wr_q.size(), 0);
    wr_q.delete();
    tick_exp_q.delete();
    @(negedge clk); reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    reset = 1'b1; start = 1'b0; stop = 1'b0; snap_req = 1'b0; period_in = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // period 20: config writes, then ticks 21 cycles apart
    do_start(32'd20);
    expect_ticks(5);
    check("five_ticks", {16'd0, tick_count}, 5);
    do_stop(1'b0);

    // snapshots on a long period, including coalesced requests
    do_start(32'h0003_0000);
    do_snap(1'b0);
    do_snap(1'b1);
    do_stop(1'b0);

    // stop coinciding with irq: ACK first, then halt
    do_start(32'd30);
    expect_ticks(1);
    do_stop(1'b1);

    // period 0 selects the default load value
    do_start(32'd0);
    do_stop(1'b0);

    // randomized runs
    for (int it = 0; it < 6; it++) begin
      do_start(32'($urandom_range(80, 40)));
      expect_ticks(int'($urandom_range(4, 2)));
      @(negedge clk); start = 1'b1; period_in = $urandom;
      @(negedge clk); start = 1'b0;
      if ($urandom_range(1, 0) == 1) begin
        expect_ticks(1);
        do_snap($urandom_range(1, 0) == 1);
      end
      expect_ticks(1);
      do_stop($urandom_range(1, 0) == 1);
    end

    // tick_count wrap: preload 0xFFFF, next tick must read 0
    do_start(32'd2);
    expect_ticks(1);
    force dut.tick_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.tick_count_q;
    exp_cnt = 16'hFFFF;
    expect_ticks(2);
    apply_reset();

    // reset during the first read cycle of a snapshot sequence
    do_start(32'h0003_0000);
    do_snap(1'b0);
    wr_q.push_back(mk_wr(3'd4, 16'h0000, 1'b0));
    @(negedge clk); snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    k = 0;
    while (!(chipselect && write_n && address == 3'd4) && k < 10) begin @(negedge clk); k++; end
    if (!(chipselect && write_n && address == 3'd4)) fail_now("wait_snap_rl");
    apply_reset();

    // normal operation after the abort
    do_start(32'd25);
    expect_ticks(2);
    do_stop(1'b1);

    repeat (5) @(negedge clk);
    check("final_wr_queue_empty", wr_q.size(), 0);
    check("final_tick_queue_empty", tick_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_tick_master.md
Name: timer_tick_master

Overview:
- Avalon-MM master that drives the system's 16-bit interval-timer slave: it programs the period and control registers, services the timeout interrupt, and reads counter snapshots.
- Presents a simple start/stop/tick interface to game logic (e.g. snake step pacing), so no CPU is needed to babysit the timer.
- Sits between the game-logic clock domain user and the timer's s1 slave port. Both are on the same single clock.

Parameters:
- DEFAULT_PERIOD, 32'h0001D4BF, load value substituted when period_in == 0.
- TICK_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request: program period_in and run continuously.
- stop  in  1  one-cycle request: stop the timer.
- period_in  in  32  timer load value, sampled on an accepted start.
- snap_req  in  1  one-cycle request: capture the live counter value.
- tick  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  serviced timeouts since the last start; wraps.
- snapshot  out  32  last captured counter value.
- snap_valid  out  1  one-cycle pulse when snapshot updates.
- busy  out  1  high in any state except IDLE and RUN.
- running  out  1  high from CFG_CTRL completion until the stop write.
- address  out  3  slave word address.
- chipselect  out  1  slave select.
- write_n  out  1  active-low write.
- writedata  out  16  write data.
- readdata  in  16  slave read data. It is registered and reflects the address presented one cycle earlier.
- irq  in  1  slave timeout interrupt, level, sticky until a status write.

Behaviour:
- Reset values: chipselect=0, write_n=1, address=0, writedata=0, tick=0, snap_valid=0, busy=0, running=0, tick_count=0, snapshot=0. State goes to IDLE and pending flags clear.
- Reset mid-sequence aborts immediately. No partial write is completed.
- Slave has no waitrequest. Every write completes in the cycle chipselect&~write_n is asserted. Read data is captured exactly 2 cycles after the address is first driven.
- Register map: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- IDLE:
  - On start, latch P = (period_in==0 ? DEFAULT_PERIOD : period_in), clear tick_count, go to CFG_PL.
  - stop and snap_req are ignored in IDLE.
- CFG_PL: write addr2 with P[15:0]. Next state CFG_PH.
- CFG_PH: write addr3 with P[31:16]. Next state CFG_CTRL.
- CFG_CTRL: write addr1 with 16'h0007. Next state RUN; running goes to 1.
- RUN: bus idle (chipselect=0). Priority when requests coincide: irq > stop (or pending stop) > snap_req (or pending snap). start is ignored while running.
  - irq -> ACK.
  - stop -> STOP_W.
  - snap -> SNAP_W.
- ACK:
  - Write addr0 with 16'h0000.
  - In the same cycle: tick=1, tick_count += 1 (modulo 2^TICK_W, 0xFFFF -> 0).
  - Next state RUN. irq is low again from the next cycle.
- STOP_W: write addr1 with 16'h0008. Next state IDLE; running goes to 0. A still-asserted irq is not serviced.
- Snapshot sequence:
  - SNAP_W: write addr4 (any data).
  - SNAP_RL: address=4, read only.
  - SNAP_RH: address=5; capture readdata into snapshot[15:0].
  - SNAP_CAP: capture readdata into snapshot[31:16]; snap_valid=1 in the same cycle. Return to RUN.
- Requests arriving while busy:
  - stop or snap_req set a pending flag, consumed in RUN by the priority order.
  - Multiple snap_req pulses coalesce to one.
  - irq needs no latch: the slave holds it.
- Missed timeouts: if two or more timeouts occur before ACK, only one tick is produced. Accepted.
- Bus outputs are registered. chipselect is asserted only in write or read states.

Decomposition:
- Package timer_master_pkg holds:
  - address constants ADDR_STATUS..ADDR_SNAP_H;
  - control bit indices CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP;
  - control words CTRL_RUN=16'h0007 and CTRL_HALT=16'h0008;
  - the state enum.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset then start with period_in=32'd20 (bench drives the interval-timer slave model) -> writes in consecutive cycles: addr2 data 0x0014, addr3 0x0000, addr1 0x0007; running=1 next cycle.
- Run 5 periods -> 5 tick pulses ~21 cycles apart, each preceded by an addr0 write; tick_count=5; irq never high more than 3 cycles.
- snap_req in RUN with period 32'h00030000 -> addr4 write, then addr4 and addr5 reads; snapshot equals slave counter value at the SNAP_W edge; snap_valid single pulse.
- stop coinciding with irq -> ACK first (tick_count+1), then addr1 write 0x0008, IDLE, running=0. A second start with period_in=0 programs 0xD4BF / 0x0001.
- tick_count preloaded near wrap (force after 65535 ticks, period 2) -> next tick gives tick_count=0.
- Assert reset during SNAP_RL -> next cycle chipselect=0, write_n=1, state IDLE, snapshot=0; a later start proceeds normally.
